// File: rtl/fpdiv_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpdiv_ctrl_if : start handshake and datapath controls of the Goldschmidt FSM
// Revision: 1.0
// ----------------------------------------------------------------------------
interface fpdiv_ctrl_if;
  logic       start;
  logic       sel_mux2;
  logic [1:0] sel_mux4;
  logic       en_a;
  logic       en_b;
  logic       en_c;
  logic       busy;
  logic       done;
  logic [3:0] iter;

  modport master (
    input  start,
    output sel_mux2, sel_mux4, en_a, en_b, en_c, busy, done, iter
  );

  modport slave (
    output start,
    input  sel_mux2, sel_mux4, en_a, en_b, en_c, busy, done, iter
  );
endinterface
`default_nettype wire

// File: rtl/fpdiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpdiv_ctrl : sequencing FSM for a shared-multiplier Goldschmidt divider
// Revision: 1.0
// ----------------------------------------------------------------------------
module fpdiv_ctrl #(
  parameter int NITER = 3
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fpdiv_ctrl_if.master ctl
);

  localparam logic [3:0] LAST_ITER = 4'(NITER - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q0   = 3'd1,
    D0   = 3'd2,
    QI   = 3'd3,
    DI   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] iter_q;
  logic       sel_mux2_q;
  logic [1:0] sel_mux4_q;
  logic       en_a_q;
  logic       en_b_q;
  logic       en_c_q;
  logic       busy_q;
  logic       done_q;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = ctl.start ? Q0 : IDLE;
      Q0:      state_nxt = D0;
      D0:      state_nxt = QI;
      QI:      state_nxt = (iter_q == LAST_ITER) ? DONE : DI;
      DI:      state_nxt = QI;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      iter_q     <= 4'd0;
      sel_mux2_q <= 1'b0;
      sel_mux4_q <= 2'b00;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_c_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ctl.start) begin
        iter_q <= 4'd0;
      end else if (state == DI) begin
        iter_q <= iter_q + 4'd1;
      end
      sel_mux2_q <= (state_nxt == QI) || (state_nxt == DI);
      case (state_nxt)
        D0:      sel_mux4_q <= 2'b01;
        QI:      sel_mux4_q <= 2'b10;
        DI:      sel_mux4_q <= 2'b11;
        default: sel_mux4_q <= 2'b00;
      endcase
      en_a_q <= (state_nxt == Q0) || (state_nxt == QI);
      en_b_q <= (state_nxt == D0) || (state_nxt == DI);
      en_c_q <= (state_nxt == D0) || (state_nxt == DI);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  assign ctl.sel_mux2 = sel_mux2_q;
  assign ctl.sel_mux4 = sel_mux4_q;
  assign ctl.en_a     = en_a_q;
  assign ctl.en_b     = en_b_q;
  assign ctl.en_c     = en_c_q;
  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.iter     = iter_q;

endmodule
`default_nettype wire

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 The module SHALL have parameter NITER, default 3, meaning the number of Goldschmidt quotient refinements (legal range 1..8).
REQ-002 The module SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port start  input  1  request to begin one division, sampled on the rising edge of clk.
REQ-005 The module SHALL have port sel_mux2  output  1  multiplier operand A select: 0 = initial reciprocal approximation, 1 = reg C.
REQ-006 The module SHALL have port sel_mux4  output  2  multiplier operand B select: 00 = num, 01 = denom, 10 = reg A, 11 = reg B.
REQ-007 The module SHALL have ports en_a, en_b and en_c  output  1 each  load enables for reg A (quotient), reg B (divisor) and reg C (one's-complement correction factor).
REQ-008 The module SHALL have port busy  output  1  high while a division is in progress, including the DONE cycle.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse; reg A holds the final quotient.
REQ-010 The module SHALL have port iter  output  4  current refinement index (debug).

Function
REQ-011 The FSM SHALL have states IDLE, Q0, D0, QI, DI and DONE, held in a state register with Moore-decoded outputs, and no combinational path from start to any output.
REQ-012 In IDLE, all enables SHALL be 0, selects SHALL be 0 and busy SHALL be 0; start=1 SHALL move IDLE->Q0 and clear iter to 0.
REQ-013 Q0 SHALL drive sel_mux2=0, sel_mux4=00 and en_a=1 (Q0 = N*K0), then go to D0.
REQ-014 D0 SHALL drive sel_mux2=0, sel_mux4=01, en_b=1 and en_c=1 (D0 = D*K0, C = ~D0), then go to QI.
REQ-015 QI SHALL drive sel_mux2=1, sel_mux4=10 and en_a=1, then go to DONE if iter==NITER-1, else to DI.
REQ-016 DI SHALL drive sel_mux2=1, sel_mux4=11, en_b=1 and en_c=1, increment iter, then go to QI.
REQ-017 DONE SHALL drive done=1 with all enables 0, then go to IDLE.
REQ-018 At most one of en_a and en_b SHALL be high in any cycle, and en_c SHALL equal en_b in every cycle.
REQ-019 Latency SHALL be fixed: done is high in the (2*NITER+2)th cycle after the edge that samples start (8 cycles for NITER=3).
REQ-020 start while busy=1 SHALL be ignored, and SHALL NOT restart or extend the operation.
REQ-021 start sampled high in the DONE cycle SHALL be ignored; a new division SHALL require start in IDLE (minimum of one IDLE cycle between operations).
REQ-022 iter SHALL hold its value in IDLE, DONE, Q0, D0 and QI, and SHALL NOT exceed NITER-1.
REQ-023 With NITER=1, the sequence SHALL be Q0, D0, QI, DONE with no DI cycle.
REQ-024 An illegal state encoding SHALL return to IDLE on the next clock.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force state=IDLE, iter=0, busy=0, done=0, en_a=en_b=en_c=0, sel_mux2=0 and sel_mux4=00.
REQ-026 Reset asserted mid-operation SHALL abort the division with no done pulse; after reset deasserts, the FSM SHALL wait in IDLE for a new start.
REQ-027 Reset deassertion SHALL be treated as synchronous to clk by the integrating level; the FSM SHALL take no action on the first edge unless start=1.

Verification
REQ-028 NITER=3, single start pulse -> state trace Q0,D0,QI,DI,QI,DI,QI,DONE; en_a high in cycles 1,3,5,7; en_b/en_c high in cycles 2,4,6; done high only in cycle 8.
REQ-029 Cycle-accurate datapath model with num=1.5, denom=1.25 and K0=0.75 -> reg A at done is within 2^-20 of 1.2.
REQ-030 start held high continuously -> back-to-back operations with done every 9 cycles and no overlap.
REQ-031 start pulsed during the D0 cycle of a running operation and again during DONE -> exactly one done, sequence unchanged.
REQ-032 reset=0 asserted in the DI cycle between clock edges -> all outputs 0 before the next edge; no done follows.
REQ-033 NITER=1 and NITER=8 -> done at cycles 4 and 18 respectively; iter peaks at 0 and 7.
